// File: rtl/sync_fifo.sv
// Single-clock FIFO with selectable FWFT read mode, occupancy count,
// almost-full/almost-empty flags, synchronous flush and sticky error flags.
module sync_fifo #(
   parameter int DATA_WIDTH    = 8,
   parameter int DATA_DEPTH    = 16,
   parameter int ADDR_WIDTH    = 4,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = DATA_DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DATA_DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};

   logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];
   logic [CNT_W-1:0]      wr_ptr_r;
   logic [CNT_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  empty_s;
   logic                  full_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic [ADDR_WIDTH-1:0] wr_addr_s;
   logic [ADDR_WIDTH-1:0] rd_addr_s;

   // Status decode and request acceptance, all from the registered count
   always_comb begin
      empty_s   = (count_r == ZERO_C);
      full_s    = (count_r == DEPTH_C);
      wr_acc_s  = wr_en && !full_s && !flush && !rst;
      rd_acc_s  = rd_en && !empty_s && !flush && !rst;
      wr_addr_s = wr_ptr_r[ADDR_WIDTH-1:0];
      rd_addr_s = rd_ptr_r[ADDR_WIDTH-1:0];
   end

   // Pointer, occupancy and sticky error flag state
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r    <= ZERO_C;
         rd_ptr_r    <= ZERO_C;
         count_r     <= ZERO_C;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_C;
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_C;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
         if (wr_en && full_s) begin
            overflow_r <= 1'b1;
         end
         if (rd_en && empty_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

   // Storage array; deliberately never cleared by reset or flush
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[wr_addr_s] <= wr_data;
      end
   end

   // Status outputs
   always_comb begin
      empty        = empty_s;
      full         = full_s;
      almost_empty = (count_r <= AEMPTY_C);
      almost_full  = (count_r >= AFULL_C);
      count        = count_r;
      overflow     = overflow_r;
      underflow    = underflow_r;
   end

   generate
      if (FWFT == 0) begin : g_std
         logic [DATA_WIDTH-1:0] rd_data_r;
         logic                  rd_valid_r;

         // Registered read port: data appears the cycle after the pop
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data_r  <= {DATA_WIDTH{1'b0}};
               rd_valid_r <= 1'b0;
            end else if (flush) begin
               rd_valid_r <= 1'b0;
            end else if (rd_acc_s) begin
               rd_data_r  <= mem_r[rd_addr_s];
               rd_valid_r <= 1'b1;
            end else begin
               rd_valid_r <= 1'b0;
            end
         end

         assign rd_data  = rd_data_r;
         assign rd_valid = rd_valid_r;
      end else begin : g_fwft
         // Head word is presented directly; rd_en only acknowledges it
         always_comb begin
            rd_data  = {DATA_WIDTH{1'b0}};
            rd_valid = !empty_s;
            if (!empty_s) begin
               rd_data = mem_r[rd_addr_s];
            end else begin
               rd_data = {DATA_WIDTH{1'b0}};
            end
         end
      end
   endgenerate

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO buffering data between producer and consumer logic in the same clock domain. It adds selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. Typical use is stream decoupling inside the core and peripheral paths, where the clock-domain-crossing logic of a dual-clock FIFO is not needed.

## Interface
- DATA_WIDTH, 8, width of each entry
- DATA_DEPTH, 16, number of entries; must be a power of two, ≥ 2
- ADDR_WIDTH, 4, log2(DATA_DEPTH); pointers are ADDR_WIDTH+1 bits
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_THRESH, DATA_DEPTH-2, almost_full asserts when count ≥ this value
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this value

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset; synchronous and active-high
- flush  in  1  synchronous clear of pointers, count and error flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read (pop) request
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data holds a valid popped/head word
- empty  out  1  count == 0
- full  out  1  count == DATA_DEPTH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- almost_full  out  1  count ≥ AFULL_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DATA_DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Accepted write: wr_en && !full && !flush. Stores wr_data at wr_ptr[ADDR_WIDTH-1:0], wr_ptr += 1.
- Accepted read: rd_en && !empty && !flush. rd_ptr += 1.
- full and empty come from the registered count, not the current-cycle request. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- count: +1 on accepted write only; -1 on accepted read only; unchanged when both or neither are accepted. Pointers wrap modulo 2^(ADDR_WIDTH+1).
- Standard mode (FWFT=0): on an accepted read, rd_data <= mem[rd_ptr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT mode (FWFT=1): rd_data = mem[rd_ptr] when !empty, else 0. rd_valid = !empty. rd_en acknowledges and pops the head word.
- overflow set on wr_en && full. underflow set on rd_en && empty. Both stay set until rst or flush.
- flush: rd_ptr, wr_ptr and count <= 0. overflow/underflow <= 0. rd_valid <= 0. wr_en and rd_en in the same cycle are ignored and do not set error flags. Memory contents are not cleared.
- rst has priority over flush and has the same effect, plus rd_data <= 0 in standard mode. Memory is not reset.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AFULL_THRESH>0), overflow=0, underflow=0, rd_valid=0, rd_data=0.
- Write accepted in cycle N: count, empty, full and the almost flags update in N+1.
- Standard mode: read accepted in cycle N gives rd_data/rd_valid in N+1. Minimum write-to-data latency is 2 cycles (write N, read N+1, data N+2).
- FWFT mode: a word written into an empty FIFO in cycle N appears on rd_data with rd_valid=1 in N+1. The pop takes effect in the cycle rd_en is sampled, and the next head appears in the following cycle.
- Sustained throughput is one write and one read per cycle when neither empty nor full.
- Reset or flush asserted mid-stream takes effect at the next edge. In-flight accepted requests in that cycle are discarded.

## Test plan
- Reset, then write 0x01..0x10 on 16 consecutive cycles (DEPTH=16, FWFT=0) -> full=1 and count=16 after the 16th edge. almost_full rises when count reaches 14. A 17th write sets overflow=1 with count still 16.
- Read 16 times from the full FIFO -> rd_data = 0x01..0x10 in order, each one cycle after its rd_en, rd_valid=1 for each. Then empty=1 and almost_empty=1 once count ≤ 2. An extra rd_en sets underflow=1.
- FWFT=1: write 0xA5 into the empty FIFO -> next cycle rd_data=0xA5, rd_valid=1 with no rd_en. Pulse rd_en -> the following cycle empty=1, rd_data=0, rd_valid=0.
- With count=5, assert wr_en and rd_en together for 40 cycles (wraps both pointers) -> count stays 5, data order is preserved, and no error flags are set.
- With count=16, assert wr_en and rd_en together -> the read is accepted, the write is rejected, count=15, overflow=1. With count=0, do the same -> the write is accepted, the read is rejected, count=1, underflow=1.
- With count=9 and overflow=1, assert flush together with wr_en and rd_en -> next cycle count=0, empty=1, overflow=0, underflow=0, and no write is stored.
